// File: rtl/cpu_pkg.sv
`default_nettype none
// cpu_pkg: opcodes, instruction field positions and fetch FSM encodings shared by fetch and execute.
// Rev 1.0
package cpu_pkg;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_HALT = 2'b11;

  localparam int OP_MSB   = 7;
  localparam int OP_LSB   = 6;
  localparam int DEST_MSB = 5;
  localparam int DEST_LSB = 4;
  localparam int SRC1_MSB = 3;
  localparam int SRC1_LSB = 2;
  localparam int SRC2_MSB = 1;
  localparam int SRC2_LSB = 0;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_ISSUE = 3'd3;
  localparam logic [2:0] S_HALT  = 3'd4;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/instr_decoder.sv
`default_nettype none
// instr_decoder: splits an 8-bit instruction word into opcode and three register fields.
// Rev 1.0
module instr_decoder
  import cpu_pkg::*;
(
  input  logic [7:0] instr_i,
  output logic [1:0] op_code_o,
  output logic [1:0] dest_addr_o,
  output logic [1:0] src_addr1_o,
  output logic [1:0] src_addr2_o
);

  assign op_code_o   = instr_i[OP_MSB:OP_LSB];
  assign dest_addr_o = instr_i[DEST_MSB:DEST_LSB];
  assign src_addr1_o = instr_i[SRC1_MSB:SRC1_LSB];
  assign src_addr2_o = instr_i[SRC2_MSB:SRC2_LSB];

endmodule
`default_nettype wire

// File: rtl/fetch_decode.sv
`default_nettype none
// fetch_decode: sequential fetch/decode front end with valid/ready issue to execute.
// Rev 1.0
module fetch_decode
  import cpu_pkg::*;
#(
  parameter int PC_W = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic [PC_W-1:0] imem_addr,
  output logic            imem_rd_en,
  input  logic [7:0]      imem_rdata,
  output logic [1:0]      op_code,
  output logic [1:0]      dest_addr,
  output logic [1:0]      src_addr1,
  output logic [1:0]      src_addr2,
  output logic            instr_valid,
  input  logic            exec_ready,
  output logic            halted,
  output logic [7:0]      instr_count
);

  localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

  logic [2:0]      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [7:0]      instr_q, instr_d;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    instr_d = instr_q;
    case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          pc_d    = '0;
          cnt_d   = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: state_d = S_WAIT;
      S_WAIT: begin
        instr_d = imem_rdata;
        state_d = (imem_rdata[OP_MSB:OP_LSB] == OP_HALT) ? S_HALT : S_ISSUE;
      end
      S_ISSUE: begin
        // pc wraps silently at the top of program memory
        if (exec_ready) begin
          pc_d    = pc_q + PC_ONE;
          cnt_d   = sat_inc8(cnt_q);
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      instr_q <= instr_d;
    end
  end

  // Status outputs decode straight from state so reset clears them without waiting for a clock.
  assign imem_addr   = pc_q;
  assign imem_rd_en  = (state_q == S_FETCH);
  assign instr_valid = (state_q == S_ISSUE);
  assign halted      = (state_q == S_HALT);
  assign instr_count = cnt_q;

  instr_decoder u_decoder (
    .instr_i     (instr_q),
    .op_code_o   (op_code),
    .dest_addr_o (dest_addr),
    .src_addr1_o (src_addr1),
    .src_addr2_o (src_addr2)
  );

endmodule
`default_nettype wire

// File: tb/tb_fetch_decode.sv
`default_nettype none
`timescale 1ns/1ps
// tb_fetch_decode: scoreboard bench; stimulus pushes expected fetches/issues, a monitor pops them.
// Rev 1.0
module tb_fetch_decode;

  localparam int PC_W = 2;

  logic            clk = 1'b0;
  logic            reset, start, exec_ready;
  logic [PC_W-1:0] imem_addr;
  logic            imem_rd_en, instr_valid, halted;
  logic [7:0]      imem_rdata, instr_count;
  logic [1:0]      op_code, dest_addr, src_addr1, src_addr2;

  always #5 clk = ~clk;

  fetch_decode #(.PC_W(PC_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .imem_addr   (imem_addr),
    .imem_rd_en  (imem_rd_en),
    .imem_rdata  (imem_rdata),
    .op_code     (op_code),
    .dest_addr   (dest_addr),
    .src_addr1   (src_addr1),
    .src_addr2   (src_addr2),
    .instr_valid (instr_valid),
    .exec_ready  (exec_ready),
    .halted      (halted),
    .instr_count (instr_count)
  );

  typedef struct packed {
    logic [7:0] word;
    logic [7:0] cnt;
  } issue_t;

  issue_t          issue_q[$];
  logic [PC_W-1:0] addr_q[$];
  issue_t          mon_e;
  logic [PC_W-1:0] mon_a;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [4];
  int fetch_cnt = 0;
  int base = 0;
  int halt_at = -1;

  task automatic check(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, got, exp);
    end
  endtask

  // Instruction memory: one-cycle read latency; optionally substitutes HALT at a given fetch index.
  always @(posedge clk) begin
    if (imem_rd_en) begin
      imem_rdata <= (halt_at >= 0 && (fetch_cnt - base) == halt_at) ? 8'hC0 : mem[imem_addr];
      fetch_cnt  <= fetch_cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (imem_rd_en) begin
        check("fetch_expected", int'(addr_q.size() > 0), 1);
        if (addr_q.size() > 0) begin
          mon_a = addr_q.pop_front();
          check("fetch_addr", int'(imem_addr), int'(mon_a));
        end
      end
      if (instr_valid && exec_ready) begin
        check("xfer_expected", int'(issue_q.size() > 0), 1);
        if (issue_q.size() > 0) begin
          mon_e = issue_q.pop_front();
          check("xfer_op",    int'(op_code),     int'(mon_e.word[7:6]));
          check("xfer_dest",  int'(dest_addr),   int'(mon_e.word[5:4]));
          check("xfer_src1",  int'(src_addr1),   int'(mon_e.word[3:2]));
          check("xfer_src2",  int'(src_addr2),   int'(mon_e.word[1:0]));
          check("xfer_count", int'(instr_count), int'(mon_e.cnt));
        end
      end
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_halt(input int budget, input string nm);
    int n = 0;
    while (!halted && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(nm, int'(halted), 1);
  endtask

  task automatic wait_valid(input int budget, input string nm);
    int n = 0;
    while (!instr_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(nm, int'(instr_valid), 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start = 1'b0; exec_ready = 1'b0;
    for (int i = 0; i < 4; i++) mem[i] = 8'h00;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", int'(instr_valid), 0);
    check("rst_halted", int'(halted), 0);
    check("rst_rd_en", int'(imem_rd_en), 0);
    check("rst_addr", int'(imem_addr), 0);
    check("rst_count", int'(instr_count), 0);
    check("rst_fields", int'({op_code, dest_addr, src_addr1, src_addr2}), 0);
    @(posedge clk); #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_rd_en", int'(imem_rd_en), 0);
    check("idle_valid", int'(instr_valid), 0);

    // One ADD then HALT
    mem[0] = 8'h1B; mem[1] = 8'hC0; exec_ready = 1'b1; base = fetch_cnt;
    issue_q.push_back(issue_t'{8'h1B, 8'd0});
    addr_q.push_back(2'd0); addr_q.push_back(2'd1);
    pulse_start();
    wait_halt(40, "t1_halt");
    check("t1_count", int'(instr_count), 1);
    check("t1_valid", int'(instr_valid), 0);

    // Back-pressure hold, start pulses in WAIT and ISSUE ignored
    mem[0] = 8'h6E; mem[1] = 8'hC0; exec_ready = 1'b0; base = fetch_cnt;
    issue_q.push_back(issue_t'{8'h6E, 8'd0});
    addr_q.push_back(2'd0); addr_q.push_back(2'd1);
    pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_valid(10, "t2_valid");
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("hold_valid", int'(instr_valid), 1);
      check("hold_op", int'(op_code), 1);
      check("hold_dest", int'(dest_addr), 2);
      check("hold_src1", int'(src_addr1), 3);
      check("hold_src2", int'(src_addr2), 2);
      check("hold_count", int'(instr_count), 0);
      if (k == 1) start = 1'b1;
      if (k == 2) start = 1'b0;
    end
    exec_ready = 1'b1;
    wait_halt(40, "t2_halt");
    check("t2_count", int'(instr_count), 1);

    // PC wrap with PC_W=2: addresses 0,1,2,3,0 then HALT on the sixth fetch
    for (int i = 0; i < 4; i++) mem[i] = 8'h00;
    halt_at = 5; base = fetch_cnt;
    for (int i = 0; i < 5; i++) issue_q.push_back(issue_t'{8'h00, 8'(i)});
    for (int i = 0; i < 6; i++) addr_q.push_back(2'(i % 4));
    pulse_start();
    wait_halt(80, "t3_halt");
    check("t3_count", int'(instr_count), 5);

    // 300 ADDs before HALT: counter saturates
    halt_at = 300; base = fetch_cnt;
    for (int i = 0; i < 300; i++) issue_q.push_back(issue_t'{8'h00, (i < 255) ? 8'(i) : 8'd255});
    for (int i = 0; i < 301; i++) addr_q.push_back(2'(i % 4));
    pulse_start();
    wait_halt(1300, "t4_halt");
    check("t4_count", int'(instr_count), 255);

    // Reset while an instruction is presented
    halt_at = -1; base = fetch_cnt;
    issue_q.push_back(issue_t'{8'h00, 8'd0});
    issue_q.push_back(issue_t'{8'h00, 8'd1});
    addr_q.push_back(2'd0); addr_q.push_back(2'd1); addr_q.push_back(2'd2);
    pulse_start();
    begin
      int n = 0;
      while (issue_q.size() != 0 && n < 40) begin
        @(negedge clk);
        n++;
      end
    end
    check("t5_drain", issue_q.size(), 0);
    @(posedge clk); #1 exec_ready = 1'b0;
    wait_valid(10, "t5_valid");
    @(negedge clk);
    check("t5_pre_count", int'(instr_count), 2);
    #1 reset = 1'b1;
    #1;
    check("t5_rst_valid", int'(instr_valid), 0);
    check("t5_rst_count", int'(instr_count), 0);
    check("t5_rst_rd_en", int'(imem_rd_en), 0);
    check("t5_rst_halted", int'(halted), 0);
    check("t5_rst_fields", int'({op_code, dest_addr, src_addr1, src_addr2}), 0);
    @(posedge clk); #1 reset = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("t5_idle_rd_en", int'(imem_rd_en), 0);
      check("t5_idle_valid", int'(instr_valid), 0);
    end

    check("sb_issue_left", issue_q.size(), 0);
    check("sb_addr_left", addr_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
